flappy_pipes: RTL and testbench
===============================

FLAPPY_PIPES -- requirements
Module: flappy_pipes

Interface
REQ-001 Parameter SCREEN_W, 640: pipe respawn X coordinate and horizontal play-field width.
REQ-002 Parameter SCREEN_H, 480: vertical play-field height; a bird at or beyond it is out of bounds.
REQ-003 Parameter PIPE_W, 52: pipe width in pixels.
REQ-004 Parameter GAP_H, 120: vertical opening height in pixels.
REQ-005 Parameter BIRD_SZ, 16: bird bounding-box edge in pixels.
REQ-006 Parameter SPEED, 2: pixels scrolled per Tick.
REQ-007 Clk  in  1  single system clock; all state changes on its rising edge.
REQ-008 Reset  in  1  synchronous, active-low reset; sampled on the Clk rising edge.
REQ-009 Tick  in  1  frame-advance strobe, one Clk wide.
REQ-010 Start  in  1  leave IDLE and begin scrolling.
REQ-011 Ack  in  1  acknowledge the loss and return to IDLE.
REQ-012 XBird, YBird  in  10 each  bird box origin from the bird FSM; box is [X, X+BIRD_SZ) by [Y, Y+BIRD_SZ).
REQ-013 Pipe0X, Pipe1X  out  10 each  pipe left-edge X.
REQ-014 Pipe0GapY, Pipe1GapY  out  10 each  gap lower edge; the opening is [GapY, GapY+GAP_H).
REQ-015 Score  out  8  count of pipes passed.
REQ-016 Lost  out  1  high while in LOST; feeds the bird FSM.
REQ-017 q_Idle, q_Run, q_Lost  out  1 each  one-hot state outputs.

Function
REQ-018 The block SHALL implement a one-hot FSM with states IDLE, RUN and LOST; any other encoding SHALL go to IDLE on the next edge.
REQ-019 In IDLE, Start=1 SHALL move the FSM to RUN on the next edge; Tick SHALL be ignored.
REQ-020 In RUN with Tick=1 and no collision, each PipeNX SHALL decrease by SPEED on the next edge.
REQ-021 Respawn rule: if PipeNX < SPEED when Tick arrives, PipeNX SHALL load SCREEN_W instead of wrapping, and PipeNGapY SHALL load 100 + LFSR[7:0], giving a range of 100..355.
REQ-022 The LFSR SHALL be 8 bits with polynomial x^8+x^6+x^5+x^4+1 and seed 8'hA5, and SHALL advance every cycle in every state.
REQ-023 Scoring: Score SHALL increment by 1 when a pipe's right edge (PipeNX+PIPE_W) goes from >= XBird before a Tick update to < XBird after it.
REQ-024 Score SHALL saturate at 255.
REQ-025 If both pipes score on the same Tick, Score SHALL increment by 2, still saturating at 255.
REQ-026 Collision condition, evaluated combinationally every RUN cycle from registered pipe state and the current XBird/YBird:
  - horizontal overlap with a pipe, i.e. XBird+BIRD_SZ > PipeNX and XBird < PipeNX+PIPE_W, and the bird is not fully inside that pipe's opening (YBird < GapY or YBird+BIRD_SZ > GapY+GAP_H); or
  - YBird = 0; or
  - YBird+BIRD_SZ >= SCREEN_H.
REQ-027 A collision in RUN SHALL move the FSM to LOST on the next edge, so Lost rises one cycle after the condition is presented.
REQ-028 If a collision and a Tick occur in the same cycle, LOST SHALL take priority: positions and Score SHALL stay frozen.
REQ-029 In LOST, positions and Score SHALL hold, and Start and Tick SHALL be ignored.
REQ-030 In LOST, Ack=1 SHALL restore pipe positions, gaps and Score to their reset values and enter IDLE on the next edge; the LFSR SHALL NOT be restored.
REQ-031 All intermediate sums SHALL be computed at 11 bits so that PipeNX+PIPE_W and YBird+BIRD_SZ never wrap.

Reset
REQ-032 Reset=0 at a rising edge SHALL override all other inputs in every state, including mid-scroll.
REQ-033 Reset values: state IDLE; Pipe0X=SCREEN_W (640); Pipe1X=SCREEN_W+320 (960); Pipe0GapY=Pipe1GapY=200; Score=0; Lost=0; LFSR=8'hA5.

Verification
REQ-034 Scroll: Reset, then Start, then 10 Ticks with the bird at (144,260) -> Pipe0X=620, Pipe1X=940, Lost=0, q_Run=1.
REQ-035 Respawn: Pipe0X=1 with a Tick -> Pipe0X=640, Pipe0GapY is within 100..355, and no wrap value appears.
REQ-036 Score: bird at X=144, Pipe0X=94 (right edge 146), one Tick -> right edge 144, no score; next Tick -> edge 142, Score=1.
REQ-037 Collision: Pipe0X=150, GapY=200, YBird=190 -> Lost=1 exactly one cycle later; a simultaneous Tick leaves Pipe0X=150; Ack -> IDLE with reset values restored.
REQ-038 Bounds and reset: YBird=464 in RUN -> LOST; Reset=0 asserted during RUN with Tick=1 -> all reset values on the next edge.

Source files
------------

// File: rtl/flappy_pipes.sv
// -----------------------------------------------------------------------------
// flappy_pipes
//   Pipe scroller, scorer and collision detector for a Flappy-Bird style game.
//   Two pipes scroll left by SPEED pixels per Tick while in RUN and respawn at
//   the right edge of the screen with a pseudo-random gap height. Passing a
//   pipe scores a point. Touching a pipe, the top row or the bottom bound moves
//   the game to LOST until Ack returns it to IDLE.
//
// Ports
//   Clk        in   system clock, rising-edge active
//   Reset      in   synchronous active-low reset
//   Tick       in   frame-advance strobe
//   Start      in   leave IDLE and begin scrolling
//   Ack        in   acknowledge the loss, clear the play field, return to IDLE
//   XBird      in   [9:0] bird box left edge
//   YBird      in   [9:0] bird box top edge
//   Pipe0X     out  [9:0] pipe 0 left edge
//   Pipe1X     out  [9:0] pipe 1 left edge
//   Pipe0GapY  out  [9:0] pipe 0 opening start, opening is [GapY, GapY+GAP_H)
//   Pipe1GapY  out  [9:0] pipe 1 opening start
//   Score      out  [7:0] pipes passed, saturating at 255
//   Lost       out  high while in LOST
//   q_Idle     out  one-hot state flag IDLE
//   q_Run      out  one-hot state flag RUN
//   q_Lost     out  one-hot state flag LOST
// -----------------------------------------------------------------------------
module flappy_pipes #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int PIPE_W   = 52,
    parameter int GAP_H    = 120,
    parameter int BIRD_SZ  = 16,
    parameter int SPEED    = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Start,
    input  logic       Ack,
    input  logic [9:0] XBird,
    input  logic [9:0] YBird,
    output logic [9:0] Pipe0X,
    output logic [9:0] Pipe1X,
    output logic [9:0] Pipe0GapY,
    output logic [9:0] Pipe1GapY,
    output logic [7:0] Score,
    output logic       Lost,
    output logic       q_Idle,
    output logic       q_Run,
    output logic       q_Lost
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        LOST = 3'b100
    } state_t;

    // Geometry constants sized to the datapath; sums are formed at 11 bits so
    // that edge + width never wraps.
    localparam logic [9:0]  SCREEN_W10 = 10'(SCREEN_W);
    localparam logic [9:0]  PIPE1_X0   = 10'(SCREEN_W + 320);
    localparam logic [9:0]  GAP_RST    = 10'd200;
    localparam logic [9:0]  GAP_BASE   = 10'd100;
    localparam logic [9:0]  SPEED10    = 10'(SPEED);
    localparam logic [10:0] SCREEN_H11 = 11'(SCREEN_H);
    localparam logic [10:0] PIPE_W11   = 11'(PIPE_W);
    localparam logic [10:0] GAP_H11    = 11'(GAP_H);
    localparam logic [10:0] BIRD_SZ11  = 11'(BIRD_SZ);
    localparam logic [7:0]  LFSR_SEED  = 8'hA5;

    state_t      state;
    state_t      state_next;

    logic [9:0]  pipe0_x;
    logic [9:0]  pipe1_x;
    logic [9:0]  gap0_y;
    logic [9:0]  gap1_y;
    logic [7:0]  score;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;

    logic        do_tick;
    logic        do_clear;

    logic [10:0] bird_x11;
    logic [10:0] bird_right;
    logic [10:0] bird_bottom;
    logic [10:0] pipe0_right;
    logic [10:0] pipe1_right;
    logic [10:0] gap0_bottom;
    logic [10:0] gap1_bottom;
    logic        hit0;
    logic        hit1;
    logic        collide;

    logic        respawn0;
    logic        respawn1;
    logic [9:0]  pipe0_x_next;
    logic [9:0]  pipe1_x_next;
    logic [9:0]  gap_new;
    logic        pass0;
    logic        pass1;
    logic [8:0]  score_sum;
    logic [7:0]  score_next;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting towards the MSB.
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // ---------------------------------------------------------------------
    // Collision detection from registered pipes and the live bird position
    // ---------------------------------------------------------------------
    always_comb begin
        bird_x11    = {1'b0, XBird};
        bird_right  = {1'b0, XBird} + BIRD_SZ11;
        bird_bottom = {1'b0, YBird} + BIRD_SZ11;
        pipe0_right = {1'b0, pipe0_x} + PIPE_W11;
        pipe1_right = {1'b0, pipe1_x} + PIPE_W11;
        gap0_bottom = {1'b0, gap0_y} + GAP_H11;
        gap1_bottom = {1'b0, gap1_y} + GAP_H11;

        hit0 = (bird_right > {1'b0, pipe0_x}) && (bird_x11 < pipe0_right) &&
               ((YBird < gap0_y) || (bird_bottom > gap0_bottom));
        hit1 = (bird_right > {1'b0, pipe1_x}) && (bird_x11 < pipe1_right) &&
               ((YBird < gap1_y) || (bird_bottom > gap1_bottom));

        collide = hit0 || hit1 || (YBird == '0) || (bird_bottom >= SCREEN_H11);
    end

    // ---------------------------------------------------------------------
    // Scroll, respawn and scoring for the next Tick
    // ---------------------------------------------------------------------
    always_comb begin
        respawn0     = pipe0_x < SPEED10;
        respawn1     = pipe1_x < SPEED10;
        pipe0_x_next = respawn0 ? SCREEN_W10 : pipe0_x - SPEED10;
        pipe1_x_next = respawn1 ? SCREEN_W10 : pipe1_x - SPEED10;
        gap_new      = GAP_BASE + {2'b00, lfsr};

        // A pipe scores when its right edge crosses from at/after the bird's
        // left edge to strictly before it across this Tick.
        pass0 = (pipe0_right >= bird_x11) &&
                (({1'b0, pipe0_x_next} + PIPE_W11) < bird_x11);
        pass1 = (pipe1_right >= bird_x11) &&
                (({1'b0, pipe1_x_next} + PIPE_W11) < bird_x11);

        score_sum  = {1'b0, score} + {8'd0, pass0} + {8'd0, pass1};
        score_next = score_sum[8] ? '1 : score_sum[7:0];
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_tick    = 1'b0;
        do_clear   = 1'b0;
        q_Idle     = 1'b0;
        q_Run      = 1'b0;
        q_Lost     = 1'b0;
        case (state)
            IDLE: begin
                q_Idle = 1'b1;
                if (Start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                q_Run = 1'b1;
                // A collision outranks a coincident Tick: the field freezes.
                if (collide) begin
                    state_next = LOST;
                end else if (Tick) begin
                    do_tick = 1'b1;
                end
            end
            LOST: begin
                q_Lost = 1'b1;
                if (Ack) begin
                    do_clear   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Lost = q_Lost;

    // ---------------------------------------------------------------------
    // Play-field registers; the LFSR free-runs and survives Ack
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pipe0_x <= SCREEN_W10;
            pipe1_x <= PIPE1_X0;
            gap0_y  <= GAP_RST;
            gap1_y  <= GAP_RST;
            score   <= '0;
            lfsr    <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next;
            if (do_clear) begin
                pipe0_x <= SCREEN_W10;
                pipe1_x <= PIPE1_X0;
                gap0_y  <= GAP_RST;
                gap1_y  <= GAP_RST;
                score   <= '0;
            end else if (do_tick) begin
                pipe0_x <= pipe0_x_next;
                pipe1_x <= pipe1_x_next;
                if (respawn0) begin
                    gap0_y <= gap_new;
                end
                if (respawn1) begin
                    gap1_y <= gap_new;
                end
                score <= score_next;
            end
        end
    end

    assign Pipe0X    = pipe0_x;
    assign Pipe1X    = pipe1_x;
    assign Pipe0GapY = gap0_y;
    assign Pipe1GapY = gap1_y;
    assign Score     = score;

endmodule

// File: tb/tb_flappy_pipes.sv
// -----------------------------------------------------------------------------
// tb_flappy_pipes
//   Bench for flappy_pipes. A behavioural model predicts the registered
//   outputs for every clock; predictions are queued as each cycle is driven
//   and popped and compared once the edge has happened.
// -----------------------------------------------------------------------------
module tb_flappy_pipes;

    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] x1;
        logic [9:0] g0;
        logic [9:0] g1;
        logic [7:0] score;
        logic [2:0] st;     // {lost, run, idle}
        logic       lost;
    } snap_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Tick = 1'b0;
    logic       Start = 1'b0;
    logic       Ack = 1'b0;
    logic [9:0] XBird = 10'd144;
    logic [9:0] YBird = 10'd260;
    logic [9:0] Pipe0X, Pipe1X, Pipe0GapY, Pipe1GapY;
    logic [7:0] Score;
    logic       Lost, q_Idle, q_Run, q_Lost;

    int    errors = 0;
    int    checks = 0;
    snap_t exp_q[$];
    snap_t m;
    logic [7:0] m_lfsr;
    snap_t e;
    snap_t got;

    flappy_pipes #(
        .SCREEN_W (640),
        .SCREEN_H (480),
        .PIPE_W   (52),
        .GAP_H    (120),
        .BIRD_SZ  (16),
        .SPEED    (2)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Tick      (Tick),
        .Start     (Start),
        .Ack       (Ack),
        .XBird     (XBird),
        .YBird     (YBird),
        .Pipe0X    (Pipe0X),
        .Pipe1X    (Pipe1X),
        .Pipe0GapY (Pipe0GapY),
        .Pipe1GapY (Pipe1GapY),
        .Score     (Score),
        .Lost      (Lost),
        .q_Idle    (q_Idle),
        .q_Run     (q_Run),
        .q_Lost    (q_Lost)
    );

    always #5 Clk = ~Clk;

    function automatic snap_t reset_snap();
        snap_t s;
        s.x0 = 10'd640;  s.x1 = 10'd960;
        s.g0 = 10'd200;  s.g1 = 10'd200;
        s.score = 8'd0;  s.st = 3'b001;  s.lost = 1'b0;
        return s;
    endfunction

    function automatic snap_t observe();
        snap_t s;
        s = {Pipe0X, Pipe1X, Pipe0GapY, Pipe1GapY, Score, q_Lost, q_Run, q_Idle, Lost};
        return s;
    endfunction

    function automatic bit hits(input int x, input int g, input int xb, input int yb);
        return (xb + 16 > x) && (xb < x + 52) && ((yb < g) || (yb + 16 > g + 120));
    endfunction

    // Drive one clock of stimulus, queue the model's prediction, take the edge.
    task automatic cycle(input logic rst, input logic tk, input logic go,
                         input logic ak, input int xb, input int yb);
        snap_t      n;
        logic [7:0] nl;
        int         inc;
        bit         coll;
        Reset = rst; Tick = tk; Start = go; Ack = ak;
        XBird = 10'(xb); YBird = 10'(yb);
        n  = m;
        nl = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        if (!rst) begin
            n  = reset_snap();
            nl = 8'hA5;
        end else if (m.st == 3'b001) begin
            if (go) n.st = 3'b010;
        end else if (m.st == 3'b010) begin
            coll = hits(int'(m.x0), int'(m.g0), xb, yb) || hits(int'(m.x1), int'(m.g1), xb, yb) ||
                   (yb == 0) || (yb + 16 >= 480);
            if (coll) begin
                n.st = 3'b100;
            end else if (tk) begin
                n.x0 = (m.x0 < 2) ? 10'd640 : m.x0 - 10'd2;
                n.x1 = (m.x1 < 2) ? 10'd640 : m.x1 - 10'd2;
                if (m.x0 < 2) n.g0 = 10'd100 + {2'b00, m_lfsr};
                if (m.x1 < 2) n.g1 = 10'd100 + {2'b00, m_lfsr};
                inc = 0;
                if (int'(m.x0) + 52 >= xb && int'(n.x0) + 52 < xb) inc++;
                if (int'(m.x1) + 52 >= xb && int'(n.x1) + 52 < xb) inc++;
                n.score = (int'(m.score) + inc > 255) ? 8'd255 : 8'(int'(m.score) + inc);
            end
        end else if (ak) begin
            n = reset_snap();
        end
        n.lost = n.st[2];
        exp_q.push_back(n);
        m      = n;
        m_lfsr = nl;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 1, 1, 1, 144, 260);
        e = exp_q.pop_front(); got = observe(); checks++;
        if (got !== e) begin errors++; $display("FAIL reset: got %h expected %h", got, e); end
        // Tick in IDLE must not move anything.
        repeat (3) begin
            cycle(1, 1, 0, 0, 144, 260);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL idle_tick: got %h expected %h", got, e); end
        end
    endtask

    task automatic test_scroll();
        cycle(1, 0, 1, 0, 144, 260);
        e = exp_q.pop_front(); got = observe(); checks++;
        if (got !== e) begin errors++; $display("FAIL start: got %h expected %h", got, e); end
        repeat (10) begin
            cycle(1, 1, 0, 0, 144, 260);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL scroll: got %h expected %h", got, e); end
        end
        checks++;
        if (Pipe0X !== 10'd620 || Pipe1X !== 10'd940 || Lost !== 1'b0 || q_Run !== 1'b1) begin
            errors++;
            $display("FAIL scroll10: got x0=%0d x1=%0d lost=%b run=%b expected 620 940 0 1",
                     Pipe0X, Pipe1X, Lost, q_Run);
        end
    endtask

    task automatic test_score();
        // 620 -> 94 through the gap (bird 260..276 inside 200..320)
        repeat (263) begin
            cycle(1, 1, 0, 0, 144, 260);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL approach: got %h expected %h", got, e); end
        end
        for (int unsigned i = 0; i < 2; i++) begin
            cycle(1, 1, 0, 0, 144, 260);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL score_step: got %h expected %h", got, e); end
            checks++;
            if (Score !== 8'(i)) begin
                errors++;
                $display("FAIL score_edge: got score=%0d x0=%0d expected %0d", Score, Pipe0X, i);
            end
        end
    endtask

    task automatic test_respawn();
        // 90 -> 2, then 2 -> 0 (no respawn), then 0 -> 640
        repeat (44) begin
            cycle(1, 1, 0, 0, 144, 260);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL to_edge: got %h expected %h", got, e); end
        end
        cycle(1, 1, 0, 0, 144, 260);
        e = exp_q.pop_front(); got = observe(); checks++;
        if (got !== e || Pipe0X !== 10'd0) begin
            errors++; $display("FAIL reach_zero: got %h expected %h", got, e);
        end
        cycle(1, 1, 0, 0, 144, 260);
        e = exp_q.pop_front(); got = observe(); checks++;
        if (got !== e) begin errors++; $display("FAIL respawn: got %h expected %h", got, e); end
        checks++;
        if (Pipe0X !== 10'd640 || Pipe0GapY < 10'd100 || Pipe0GapY > 10'd355) begin
            errors++;
            $display("FAIL respawn_range: got x0=%0d gap=%0d expected 640 and 100..355", Pipe0X, Pipe0GapY);
        end
    endtask

    task automatic test_collision();
        cycle(0, 0, 0, 0, 144, 260);
        void'(exp_q.pop_front());
        cycle(1, 0, 1, 0, 144, 260);
        void'(exp_q.pop_front());
        repeat (245) begin
            cycle(1, 1, 0, 0, 144, 260);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL col_approach: got %h expected %h", got, e); end
        end
        // Bird top 190 above the opening at 200, with a coincident Tick.
        cycle(1, 1, 0, 0, 144, 190);
        e = exp_q.pop_front(); got = observe(); checks++;
        if (got !== e || Lost !== 1'b1 || Pipe0X !== 10'd150) begin
            errors++; $display("FAIL collide: got %h expected %h", got, e);
        end
        // Start and Tick are ignored while LOST.
        repeat (2) begin
            cycle(1, 1, 1, 0, 144, 260);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin errors++; $display("FAIL lost_hold: got %h expected %h", got, e); end
        end
        cycle(1, 0, 0, 1, 144, 260);
        e = exp_q.pop_front(); got = observe(); checks++;
        if (got !== e || q_Idle !== 1'b1 || Pipe0X !== 10'd640 || Score !== 8'd0) begin
            errors++; $display("FAIL ack: got %h expected %h", got, e);
        end
    endtask

    task automatic test_bounds();
        int ys[4];
        ys = '{463, 464, 1, 0};
        foreach (ys[k]) begin
            cycle(1, 0, 1, 0, 144, 260);
            void'(exp_q.pop_front());
            cycle(1, 1, 0, 0, 144, ys[k]);
            e = exp_q.pop_front(); got = observe(); checks++;
            if (got !== e) begin
                errors++; $display("FAIL bound_y%0d: got %h expected %h", ys[k], got, e);
            end
            cycle(1, 0, 0, 1, 144, 260);
            void'(exp_q.pop_front());
            // Recover to a known IDLE whichever way the bound went.
            cycle(0, 0, 0, 0, 144, 260);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_midrun();
        cycle(1, 0, 1, 0, 144, 260);
        void'(exp_q.pop_front());
        repeat (7) begin
            cycle(1, 1, 0, 0, 144, 260);
            void'(exp_q.pop_front());
        end
        cycle(0, 1, 1, 0, 144, 260);
        e = exp_q.pop_front(); got = observe(); checks++;
        if (got !== e || Pipe0X !== 10'd640 || q_Idle !== 1'b1) begin
            errors++; $display("FAIL reset_midrun: got %h expected %h", got, e);
        end
    endtask

    initial begin
        m      = reset_snap();
        m_lfsr = 8'hA5;
        #1;
        test_reset();
        test_scroll();
        test_score();
        test_respawn();
        test_collision();
        test_bounds();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
